// File: rtl/sevenseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver stepped by rising edges of a slow tick input.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_TICKS = 1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      tick_in,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_start,
  output logic [1:0]                state_dbg
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0]         LAST     = DW'(NUM_DIGITS - 1);
  localparam logic [3:0]            GAP_LOAD = (BLANK_TICKS > 0) ? 4'(BLANK_TICKS - 1) : 4'd0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;

  state_t                    state;
  logic [DW-1:0]             digit;
  logic [3:0]                gap_cnt;
  logic                      tick_q;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic [NUM_DIGITS-1:0]     shadow_dp;

  logic                      tick_rise;
  logic                      wrap;
  logic                      advance;
  logic [DW-1:0]             next_digit;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] seg_for(input logic [4*NUM_DIGITS-1:0] nib, input logic [DW-1:0] k);
    logic [6:0] s;
`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;
`endif
    s = hex_decode(nib[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never blanked so a value of zero still reads "0".
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(k) && nib[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    if (k != '0 && upper_zero) s = 7'h00;
`endif
    return ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] an_for(input logic [DW-1:0] k);
    logic [NUM_DIGITS-1:0] a;
    a    = '0;
    a[k] = 1'b1;
    return ACTIVE_LOW ? ~a : a;
  endfunction

  function automatic logic dp_for(input logic [NUM_DIGITS-1:0] dps, input logic [DW-1:0] k);
    return ACTIVE_LOW ? ~dps[k] : dps[k];
  endfunction

  assign tick_rise = tick_in & ~tick_q;
  assign state_dbg = state;

  // Leaving IDLE behaves like a wrap onto digit 0, so both share the shadow-reload path.
  always_comb begin
    wrap       = (state == IDLE) || (digit == LAST);
    next_digit = wrap ? '0 : digit + 1'b1;
    advance    = (state == IDLE) ||
                 (state == SHOW && BLANK_TICKS == 0) ||
                 (state == GAP && gap_cnt == 4'd0);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      digit       <= '0;
      gap_cnt     <= 4'd0;
      tick_q      <= 1'b0;
      shadow      <= '0;
      shadow_dp   <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      tick_q      <= tick_in;
      frame_start <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        digit   <= '0;
        gap_cnt <= 4'd0;
        an      <= AN_OFF;
        seg     <= SEG_OFF;
        dp      <= DP_OFF;
      end else if (tick_rise) begin
        if (advance) begin
          state <= SHOW;
          digit <= next_digit;
          an    <= an_for(next_digit);
          seg   <= seg_for(wrap ? value_in : shadow, next_digit);
          dp    <= dp_for(wrap ? dp_in : shadow_dp, next_digit);
          if (wrap) begin
            shadow      <= value_in;
            shadow_dp   <= dp_in;
            frame_start <= 1'b1;
          end
        end else if (state == SHOW) begin
          state   <= GAP;
          gap_cnt <= GAP_LOAD;
          an      <= AN_OFF;
          seg     <= SEG_OFF;
          dp      <= DP_OFF;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

endmodule
